// File: rtl/piarb_rd_sched_pkg.sv
// piarb_rd_sched_pkg: shared types, default widths and helpers for the PIARB read scheduler
// Provides the FSM state encoding, default field widths taken from the codebase
// width macros (given fallbacks when those macros are absent) and the
// round-robin pointer advance helper.
`ifndef PU_ID_NBITS
`define PU_ID_NBITS 2
`endif
`ifndef PIARB_BUF_PTR_NBITS
`define PIARB_BUF_PTR_NBITS 8
`endif
`ifndef PIARB_BUF_PTR_LSB_NBITS
`define PIARB_BUF_PTR_LSB_NBITS 2
`endif
package piarb_rd_sched_pkg;
   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
   localparam int DEF_ID_NBITS = `PU_ID_NBITS;
   localparam int DEF_BPTR_NBITS = `PIARB_BUF_PTR_NBITS;
   localparam int DEF_BPTR_LSB_NBITS = `PIARB_BUF_PTR_LSB_NBITS;
   function automatic int rr_next(input int g, input int n);
      return (g + 1) % n;
   endfunction
endpackage

// File: rtl/piarb_rd_sched_rr_arb.sv
// piarb_rr_arb: N-wide round-robin arbiter, first request at or after ptr wins
// Ports:
//   req      in   N    request vector
//   ptr      in   IW   highest-priority index
//   gnt      out  N    one-hot grant (zero when no request)
//   gnt_idx  out  IW   index of the granted requester
//   gnt_vld  out  1    any request present
module piarb_rr_arb #(
   parameter int N = 4,
   localparam int IW = N > 1 ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_vld
);
   logic [31:0] j;
   // Scan from the farthest offset down so the nearest request at/after ptr overwrites.
   always_comb begin
      j = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (32'(ptr) + 32'(k)) % 32'(N);
         if (req[j[IW-1:0]]) begin
            gnt_idx = j[IW-1:0];
            gnt_vld = 1'b1;
         end
      end
      gnt = gnt_vld ? N'(1) << gnt_idx : '0;
   end
endmodule

// File: rtl/piarb_rd_sched.sv
// piarb_rd_sched: round-robin read scheduler walking buffers line by line under per-port credits
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   req_valid/req_ready          per-requester descriptor handshake (ready is a one-hot pulse)
//   req_dst_port_id, req_buf_ptr, req_last_lsb, req_sop, req_eop, req_inst
//                                packed per-requester descriptor fields
//   credit_return                one credit back per set bit per cycle
//   data_req + data_req_*        registered memory read request and its fields
//   cred_err                     sticky: credit returned into a full counter
// Build option PIARB_RD_SCHED_PKT_LOCK_EN: after an eop=0 buffer only the same
// requester is granted until it delivers its eop=1 buffer.
module piarb_rd_sched
   import piarb_rd_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int N_DST = 4,
   parameter int ID_NBITS = DEF_ID_NBITS,
   parameter int BPTR_NBITS = DEF_BPTR_NBITS,
   parameter int BPTR_LSB_NBITS = DEF_BPTR_LSB_NBITS,
   parameter int CREDITS = 8
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [N_REQ-1:0]                  req_valid,
   output logic [N_REQ-1:0]                  req_ready,
   input  logic [N_REQ*ID_NBITS-1:0]         req_dst_port_id,
   input  logic [N_REQ*BPTR_NBITS-1:0]       req_buf_ptr,
   input  logic [N_REQ*BPTR_LSB_NBITS-1:0]   req_last_lsb,
   input  logic [N_REQ-1:0]                  req_sop,
   input  logic [N_REQ-1:0]                  req_eop,
   input  logic [N_REQ-1:0]                  req_inst,
   input  logic [N_DST-1:0]                  credit_return,
   output logic                              data_req,
   output logic [ID_NBITS-1:0]               data_req_src_port_id,
   output logic [ID_NBITS-1:0]               data_req_dst_port_id,
   output logic                              data_req_sop,
   output logic                              data_req_eop,
   output logic                              data_req_inst,
   output logic [BPTR_NBITS-1:0]             data_req_buf_ptr,
   output logic [BPTR_LSB_NBITS-1:0]         data_req_buf_ptr_lsb,
   output logic                              cred_err
);
   localparam int RW = N_REQ > 1 ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(CREDITS + 1);
   state_t state, state_nxt;
   logic [RW-1:0] rr_ptr, gnt_idx, d_src;
   logic [N_REQ-1:0] gnt, arb_req;
   logic gnt_vld, accept, fire, last, cred_ok;
   logic [BPTR_LSB_NBITS-1:0] line, d_last, sel_last;
   logic [ID_NBITS-1:0] d_dst, sel_dst;
   logic [BPTR_NBITS-1:0] d_ptr, sel_ptr;
   logic d_sop, d_eop, d_inst, sel_sop, sel_eop, sel_inst;
   logic [CW-1:0] credit [N_DST];
   logic [N_DST-1:0] dst_oh, has_cred, ovf;
`ifdef PIARB_RD_SCHED_PKT_LOCK_EN
   logic lock_vld;
   logic [RW-1:0] lock_idx;
   always_comb arb_req = lock_vld ? req_valid & (N_REQ'(1) << lock_idx) : req_valid;
`else
   always_comb arb_req = req_valid;
`endif
   piarb_rr_arb #(.N(N_REQ)) u_arb (
      .req     (arb_req),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );
   always_comb begin
      sel_dst = '0;
      sel_ptr = '0;
      sel_last = '0;
      sel_sop = 1'b0;
      sel_eop = 1'b0;
      sel_inst = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            sel_dst = req_dst_port_id[i*ID_NBITS +: ID_NBITS];
            sel_ptr = req_buf_ptr[i*BPTR_NBITS +: BPTR_NBITS];
            sel_last = req_last_lsb[i*BPTR_LSB_NBITS +: BPTR_LSB_NBITS];
            sel_sop = req_sop[i];
            sel_eop = req_eop[i];
            sel_inst = req_inst[i];
         end
      end
   end
   // Credit check uses the registered count only; same-cycle returns help next cycle.
   always_comb begin
      dst_oh = '0;
      has_cred = '0;
      ovf = '0;
      accept = state == IDLE && gnt_vld;
      req_ready = accept ? gnt : '0;
      last = line == d_last;
      for (int d = 0; d < N_DST; d++) begin
         dst_oh[d] = d_dst == ID_NBITS'(d);
         has_cred[d] = credit[d] != '0;
      end
      cred_ok = |(dst_oh & has_cred);
      fire = state == XFER && cred_ok;
      for (int d = 0; d < N_DST; d++)
         ovf[d] = credit_return[d] && !(fire && dst_oh[d]) && credit[d] == CW'(CREDITS);
      state_nxt = accept ? XFER : (fire && last) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         rr_ptr <= '0;
         line <= '0;
         d_src <= '0;
         d_dst <= '0;
         d_ptr <= '0;
         d_last <= '0;
         d_sop <= 1'b0;
         d_eop <= 1'b0;
         d_inst <= 1'b0;
         data_req <= 1'b0;
         data_req_src_port_id <= '0;
         data_req_dst_port_id <= '0;
         data_req_sop <= 1'b0;
         data_req_eop <= 1'b0;
         data_req_inst <= 1'b0;
         data_req_buf_ptr <= '0;
         data_req_buf_ptr_lsb <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            rr_ptr <= RW'(rr_next(int'(gnt_idx), N_REQ));
            d_src <= gnt_idx;
            d_dst <= sel_dst;
            d_ptr <= sel_ptr;
            d_last <= sel_last;
            d_sop <= sel_sop;
            d_eop <= sel_eop;
            d_inst <= sel_inst;
         end
         if (fire)
            line <= last ? '0 : line + 1'b1;
         data_req <= fire;
         data_req_src_port_id <= fire ? ID_NBITS'(d_src) : '0;
         data_req_dst_port_id <= fire ? d_dst : '0;
         data_req_sop <= fire && d_sop && line == '0;
         data_req_eop <= fire && d_eop && last;
         data_req_inst <= fire && d_inst;
         data_req_buf_ptr <= fire ? d_ptr : '0;
         data_req_buf_ptr_lsb <= fire ? line : '0;
      end
   end
`ifdef PIARB_RD_SCHED_PKT_LOCK_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lock_vld <= 1'b0;
         lock_idx <= '0;
      end else if (accept) begin
         lock_vld <= !sel_eop;
         lock_idx <= gnt_idx;
      end
   end
`endif
   // Consume and return on the same port cancel; a return into a full counter saturates.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int d = 0; d < N_DST; d++)
            credit[d] <= CW'(CREDITS);
         cred_err <= 1'b0;
      end else begin
         for (int d = 0; d < N_DST; d++) begin
            if (fire && dst_oh[d] && !credit_return[d])
               credit[d] <= credit[d] - 1'b1;
            else if (credit_return[d] && !(fire && dst_oh[d]) && !ovf[d])
               credit[d] <= credit[d] + 1'b1;
         end
         if (|ovf)
            cred_err <= 1'b1;
      end
   end
`ifndef SYNTHESIS
   // The memory frees a buffer only on eop or its final line, so a non-eop buffer must be full.
   always_ff @(posedge clk)
      if (rstn && accept)
         assert (sel_eop || &sel_last)
         else $error("piarb_rd_sched: eop=0 descriptor with partial last_lsb %0d", sel_last);
`endif
endmodule

// File: tb/tb_piarb_rd_sched.sv
// tb_piarb_rd_sched: table-driven and directed checks of the PIARB read scheduler
module tb_piarb_rd_sched;
   import piarb_rd_sched_pkg::*;
   localparam int ID = DEF_ID_NBITS;
   localparam int BP = DEF_BPTR_NBITS;
   localparam int LW = DEF_BPTR_LSB_NBITS;
   typedef struct {
      logic       rst;
      logic [3:0] vld;
      logic [7:0] lst;
      logic [3:0] rdy;
      logic       dr;
      logic [1:0] src;
      logic [1:0] dst;
      logic [1:0] lsb;
      logic       sop;
      logic       eop;
   } vec_t;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [3:0] req_valid = '0;
   logic [3:0] credit_return = '0;
   logic [ID-1:0] b_dst [4];
   logic [BP-1:0] b_ptr [4];
   logic [LW-1:0] b_lst [4];
   logic b_sop [4];
   logic b_eop [4];
   logic b_inst [4];
   logic [4*ID-1:0] req_dst_port_id;
   logic [4*BP-1:0] req_buf_ptr;
   logic [4*LW-1:0] req_last_lsb;
   logic [3:0] req_sop, req_eop, req_inst;
   logic [3:0] req_ready, c2_req_ready;
   logic data_req, data_req_sop, data_req_eop, data_req_inst, cred_err;
   logic [ID-1:0] data_req_src_port_id, data_req_dst_port_id;
   logic [BP-1:0] data_req_buf_ptr;
   logic [LW-1:0] data_req_buf_ptr_lsb;
   logic c2_data_req, c2_sop, c2_eop, c2_inst, c2_cred_err;
   logic [ID-1:0] c2_src, c2_dst;
   logic [BP-1:0] c2_ptr;
   logic [LW-1:0] c2_lsb;
   int n_vec = 0;
   int n_err = 0;
   vec_t tv [16];
   always #5 clk = ~clk;
   always_comb begin
      req_dst_port_id = '0;
      req_buf_ptr = '0;
      req_last_lsb = '0;
      req_sop = '0;
      req_eop = '0;
      req_inst = '0;
      for (int i = 0; i < 4; i++) begin
         req_dst_port_id[i*ID +: ID] = b_dst[i];
         req_buf_ptr[i*BP +: BP] = b_ptr[i];
         req_last_lsb[i*LW +: LW] = b_lst[i];
         req_sop[i] = b_sop[i];
         req_eop[i] = b_eop[i];
         req_inst[i] = b_inst[i];
      end
   end
   piarb_rd_sched #(.CREDITS(8)) u_dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_dst_port_id      (req_dst_port_id),
      .req_buf_ptr          (req_buf_ptr),
      .req_last_lsb         (req_last_lsb),
      .req_sop              (req_sop),
      .req_eop              (req_eop),
      .req_inst             (req_inst),
      .credit_return        (credit_return),
      .data_req             (data_req),
      .data_req_src_port_id (data_req_src_port_id),
      .data_req_dst_port_id (data_req_dst_port_id),
      .data_req_sop         (data_req_sop),
      .data_req_eop         (data_req_eop),
      .data_req_inst        (data_req_inst),
      .data_req_buf_ptr     (data_req_buf_ptr),
      .data_req_buf_ptr_lsb (data_req_buf_ptr_lsb),
      .cred_err             (cred_err)
   );
   piarb_rd_sched #(.CREDITS(2)) u_c2 (
      .clk                  (clk),
      .rstn                 (rstn),
      .req_valid            (req_valid),
      .req_ready            (c2_req_ready),
      .req_dst_port_id      (req_dst_port_id),
      .req_buf_ptr          (req_buf_ptr),
      .req_last_lsb         (req_last_lsb),
      .req_sop              (req_sop),
      .req_eop              (req_eop),
      .req_inst             (req_inst),
      .credit_return        (credit_return),
      .data_req             (c2_data_req),
      .data_req_src_port_id (c2_src),
      .data_req_dst_port_id (c2_dst),
      .data_req_sop         (c2_sop),
      .data_req_eop         (c2_eop),
      .data_req_inst        (c2_inst),
      .data_req_buf_ptr     (c2_ptr),
      .data_req_buf_ptr_lsb (c2_lsb),
      .cred_err             (c2_cred_err)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic set_desc();
      for (int i = 0; i < 4; i++) begin
         b_dst[i] = ID'((i + 2) % 4);
         b_ptr[i] = BP'(5 + i);
         b_lst[i] = '0;
         b_sop[i] = 1'b1;
         b_eop[i] = 1'b1;
         b_inst[i] = i[0];
      end
   endtask
   task automatic do_reset();
      rstn = 1'b0;
      req_valid = '0;
      credit_return = '0;
      set_desc();
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask
   task automatic cyc(input logic [3:0] cr);
      credit_return = cr;
      @(posedge clk);
      #1;
      credit_return = '0;
   endtask
   task automatic apply(input int i);
      logic [BP-1:0] eptr;
      if (tv[i].rst)
         do_reset();
      req_valid = tv[i].vld;
      for (int r = 0; r < 4; r++)
         b_lst[r] = tv[i].lst[r*2 +: 2];
      #1;
      chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d data_req", i), 32'(data_req), 32'(tv[i].dr));
      if (tv[i].dr) begin
         eptr = BP'(5) + BP'(tv[i].src);
         chk($sformatf("v%0d fields", i),
             32'({data_req_src_port_id, data_req_dst_port_id, data_req_buf_ptr_lsb,
                  data_req_sop, data_req_eop, data_req_inst, data_req_buf_ptr}),
             32'({tv[i].src, tv[i].dst, tv[i].lsb, tv[i].sop, tv[i].eop, tv[i].src[0], eptr}));
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end
   initial begin
      logic [3:0] t3_cr [7];
      logic t3_dr [7];
      logic [1:0] t3_lsb [7];
      t3_cr = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
      t3_dr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      t3_lsb = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd3};
      // single 4-line buffer from requester 0 to dst 2
      tv[0]  = '{1'b1, 4'b0001, 8'h03, 4'b0001, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
      tv[1]  = '{1'b0, 4'b0000, 8'h03, 4'b0000, 1'b1, 2'd0, 2'd2, 2'd0, 1'b1, 1'b0};
      tv[2]  = '{1'b0, 4'b0000, 8'h03, 4'b0000, 1'b1, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0};
      tv[3]  = '{1'b0, 4'b0000, 8'h03, 4'b0000, 1'b1, 2'd0, 2'd2, 2'd2, 1'b0, 1'b0};
      tv[4]  = '{1'b0, 4'b0000, 8'h03, 4'b0000, 1'b1, 2'd0, 2'd2, 2'd3, 1'b0, 1'b1};
      tv[5]  = '{1'b0, 4'b0000, 8'h03, 4'b0000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
      // all requesters valid, one-beat buffers: order 0,1,2,3,0 with an IDLE bubble each
      tv[6]  = '{1'b1, 4'b1111, 8'h00, 4'b0001, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
      tv[7]  = '{1'b0, 4'b1111, 8'h00, 4'b0000, 1'b1, 2'd0, 2'd2, 2'd0, 1'b1, 1'b1};
      tv[8]  = '{1'b0, 4'b1111, 8'h00, 4'b0010, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
      tv[9]  = '{1'b0, 4'b1111, 8'h00, 4'b0000, 1'b1, 2'd1, 2'd3, 2'd0, 1'b1, 1'b1};
      tv[10] = '{1'b0, 4'b1111, 8'h00, 4'b0100, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
      tv[11] = '{1'b0, 4'b1111, 8'h00, 4'b0000, 1'b1, 2'd2, 2'd0, 2'd0, 1'b1, 1'b1};
      tv[12] = '{1'b0, 4'b1111, 8'h00, 4'b1000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
      tv[13] = '{1'b0, 4'b1111, 8'h00, 4'b0000, 1'b1, 2'd3, 2'd1, 2'd0, 1'b1, 1'b1};
      tv[14] = '{1'b0, 4'b1111, 8'h00, 4'b0001, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
      tv[15] = '{1'b0, 4'b1111, 8'h00, 4'b0000, 1'b1, 2'd0, 2'd2, 2'd0, 1'b1, 1'b1};
      set_desc();
      for (int i = 0; i < 6; i++)
         apply(i);
      chk("credit2 after 4 beats", 32'(u_dut.credit[2]), 32'd4);
      for (int i = 6; i < 16; i++)
         apply(i);
      // two-credit instance: 4-line buffer to dst 1 stalls and resumes one beat per return
      do_reset();
      b_dst[0] = 2'd1;
      b_lst[0] = 2'd3;
      req_valid = 4'b0001;
      @(posedge clk);
      #1;
      req_valid = '0;
      for (int i = 0; i < 7; i++) begin
         cyc(t3_cr[i]);
         chk($sformatf("c2 step%0d data_req", i), 32'(c2_data_req), 32'(t3_dr[i]));
         if (t3_dr[i])
            chk($sformatf("c2 step%0d lsb/eop", i), 32'({c2_lsb, c2_eop}), 32'({t3_lsb[i], i == 6}));
      end
      // reset state, then consume+return at a full counter, then overflow return
      do_reset();
      chk("reset data_req", 32'(data_req), 32'd0);
      chk("reset cred_err", 32'(cred_err), 32'd0);
      chk("reset credit0", 32'(u_dut.credit[0]), 32'd8);
      b_dst[0] = 2'd0;
      req_valid = 4'b0001;
      @(posedge clk);
      #1;
      req_valid = '0;
      cyc(4'b0001);
      chk("cons+ret data_req", 32'(data_req), 32'd1);
      chk("cons+ret credit0", 32'(u_dut.credit[0]), 32'd8);
      chk("cons+ret cred_err", 32'(cred_err), 32'd0);
      cyc(4'b0001);
      chk("overflow cred_err", 32'(cred_err), 32'd1);
      chk("overflow credit0", 32'(u_dut.credit[0]), 32'd8);
      cyc(4'b0000);
      chk("sticky cred_err", 32'(cred_err), 32'd1);
      // packet lock: requester 0 sends eop=0 full buffer while requester 1 waits
      do_reset();
      b_lst[0] = 2'd3;
      b_eop[0] = 1'b0;
      req_valid = 4'b0011;
      #1;
      chk("lock first grant", 32'(req_ready), 32'b0001);
      @(posedge clk);
      #1;
      req_valid = 4'b0010;
      for (int i = 0; i < 4; i++)
         cyc(4'b0000);
      #1;
`ifdef PIARB_RD_SCHED_PKT_LOCK_EN
      chk("lock holds req1", 32'(req_ready), 32'b0000);
      cyc(4'b0000);
      #1;
      chk("lock still holds", 32'(req_ready), 32'b0000);
      b_eop[0] = 1'b1;
      b_lst[0] = 2'd0;
      req_valid = 4'b0011;
      #1;
      chk("lock grants req0 eop", 32'(req_ready), 32'b0001);
      @(posedge clk);
      #1;
      req_valid = 4'b0010;
      cyc(4'b0000);
      #1;
      chk("lock released", 32'(req_ready), 32'b0010);
`else
      chk("nolock grants req1", 32'(req_ready), 32'b0010);
      @(posedge clk);
      #1;
      req_valid = '0;
      cyc(4'b0000);
      chk("nolock req1 beat", 32'({data_req, data_req_src_port_id}), 32'({1'b1, 2'd1}));
`endif
      // reset in the middle of a 4-line transfer
      do_reset();
      b_lst[0] = 2'd3;
      req_valid = 4'b0001;
      @(posedge clk);
      #1;
      req_valid = '0;
      cyc(4'b0000);
      cyc(4'b0000);
      chk("pre-abort lsb1", 32'({data_req, data_req_buf_ptr_lsb}), 32'({1'b1, 2'd1}));
      #2;
      rstn = 1'b0;
      #1;
      chk("abort data_req", 32'(data_req), 32'd0);
      chk("abort credit2", 32'(u_dut.credit[2]), 32'd8);
      #1;
      rstn = 1'b1;
      req_valid = 4'b1111;
      #1;
      chk("post-abort grant", 32'(req_ready), 32'b0001);
      @(posedge clk);
      #1;
      req_valid = '0;
      cyc(4'b0000);
      chk("post-abort beat", 32'({data_req, data_req_src_port_id, data_req_buf_ptr_lsb, data_req_sop}),
          32'({1'b1, 2'd0, 2'd0, 1'b1}));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
